// File: rtl/game_pkg.sv
// game_pkg: shared cell, game-state, winner and key codes for the 3x3 board game.
package game_pkg;
   localparam logic [1:0] CELL_EMPTY = 2'b00, CELL_X = 2'b01, CELL_O = 2'b10;
   localparam logic [1:0] WIN_NONE = 2'b00, WIN_X = 2'b01, WIN_O = 2'b10, WIN_DRAW = 2'b11;
   localparam logic [7:0] KEY_UP = 8'd119, KEY_LEFT = 8'd97, KEY_DOWN = 8'd115, KEY_RIGHT = 8'd100;
   typedef enum logic [1:0] {GS_PLAY = 2'b00, GS_CHECK = 2'b01, GS_OVER = 2'b10} gs_t;
   function automatic logic is_move_key(input logic [7:0] k);
      return k == KEY_UP || k == KEY_LEFT || k == KEY_DOWN || k == KEY_RIGHT;
   endfunction
endpackage

// File: rtl/board_game_ctrl_if.sv
// board_game_ctrl_if: key/cursor inputs and game status outputs of the turn sequencer.
interface board_game_ctrl_if;
   logic [7:0]  ascii;
   logic        new_ascii;
   logic [4:0]  cursor;
   logic        move_key;
   logic [17:0] board;
   logic        player;
   logic [1:0]  game_state;
   logic [1:0]  winner;
   logic [7:0]  win_line;
   logic        illegal;
   logic [3:0]  move_count;
   modport master (output ascii, new_ascii, cursor,
                   input move_key, board, player, game_state, winner, win_line, illegal, move_count);
   modport slave (input ascii, new_ascii, cursor,
                  output move_key, board, player, game_state, winner, win_line, illegal, move_count);
endinterface

// File: rtl/win_detect.sv
// win_detect: flags every complete line (rows, columns, diagonals) owned by the given cell code.
module win_detect (
   input  logic [17:0] board,
   input  logic [1:0]  code,
   output logic [7:0]  line_hit
);
   logic [8:0] m;
   for (genvar i = 0; i < 9; i++) begin : g_cell
      assign m[i] = board[2*i +: 2] == code;
   end
   assign line_hit = {m[2] & m[4] & m[6], m[0] & m[4] & m[8],
                      m[2] & m[5] & m[8], m[1] & m[4] & m[7], m[0] & m[3] & m[6],
                      m[6] & m[7] & m[8], m[3] & m[4] & m[5], m[0] & m[1] & m[2]};
endmodule

// File: rtl/board_game_ctrl.sv
// board_game_ctrl: turn sequencer owning board, current player and outcome of the 3x3 game.
module board_game_ctrl
   import game_pkg::*;
#(
   parameter logic [7:0] KEY_PLACE    = 8'd101,
   parameter logic [7:0] KEY_RESTART  = 8'd114,
   parameter logic       FIRST_PLAYER = 1'b0
) (
   input logic               CLK,
   input logic               RESET,
   board_game_ctrl_if.slave  bus
);
   logic [2:0]  sync;
   logic        key_evt, free, move_key, move_key_n, illegal, illegal_n, player, player_n;
   logic [1:0]  mark, winner, winner_n;
   logic [3:0]  cnt, cnt_n;
   logic [7:0]  win_line, win_line_n, hit;
   logic [8:0]  sel;
   logic [17:0] board, board_n;
   gs_t         state, state_n;
   // sync[1:0] is the synchroniser, sync[2] holds the previous level for edge detection
   assign key_evt = sync[1] & ~sync[2];
   assign mark = player ? CELL_O : CELL_X;
   win_detect u_win (.board(board), .code(mark), .line_hit(hit));
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         sync     <= '0;
         state    <= GS_PLAY;
         board    <= '0;
         player   <= FIRST_PLAYER;
         winner   <= WIN_NONE;
         win_line <= '0;
         cnt      <= '0;
         move_key <= 1'b0;
         illegal  <= 1'b0;
      end else begin
         sync     <= {sync[1:0], bus.new_ascii};
         state    <= state_n;
         board    <= board_n;
         player   <= player_n;
         winner   <= winner_n;
         win_line <= win_line_n;
         cnt      <= cnt_n;
         move_key <= move_key_n;
         illegal  <= illegal_n;
      end
   always_comb begin
      state_n    = state;
      board_n    = board;
      player_n   = player;
      winner_n   = winner;
      win_line_n = win_line;
      cnt_n      = cnt;
      move_key_n = 1'b0;
      illegal_n  = 1'b0;
      sel        = '0;
      free       = 1'b0;
      for (int i = 0; i < 9; i++)
         if (bus.cursor == 5'(i + 1)) begin
            sel[i] = 1'b1;
            free   = board[2*i +: 2] == CELL_EMPTY;
         end
      if (key_evt && bus.ascii == KEY_RESTART) begin
         board_n    = '0;
         winner_n   = WIN_NONE;
         win_line_n = '0;
         cnt_n      = '0;
         player_n   = FIRST_PLAYER;
         state_n    = GS_PLAY;
      end else
         case (state)
            GS_PLAY:
               if (key_evt && is_move_key(bus.ascii)) move_key_n = 1'b1;
               else if (key_evt && bus.ascii == KEY_PLACE) begin
                  if (free) begin
                     for (int i = 0; i < 9; i++)
                        if (sel[i]) board_n[2*i +: 2] = mark;
                     cnt_n   = cnt + 4'd1;
                     state_n = GS_CHECK;
                  end else illegal_n = 1'b1;
               end
            GS_CHECK:
               if (|hit) begin
                  winner_n   = mark;
                  win_line_n = hit;
                  state_n    = GS_OVER;
               end else if (cnt == 4'd9) begin
                  winner_n   = WIN_DRAW;
                  win_line_n = '0;
                  state_n    = GS_OVER;
               end else begin
                  player_n = ~player;
                  state_n  = GS_PLAY;
               end
            GS_OVER: state_n = GS_OVER;
            default: state_n = GS_PLAY;
         endcase
   end
   assign bus.move_key   = move_key;
   assign bus.board      = board;
   assign bus.player     = player;
   assign bus.game_state = state;
   assign bus.winner     = winner;
   assign bus.win_line   = win_line;
   assign bus.illegal    = illegal;
   assign bus.move_count = cnt;
endmodule

// File: tb/tb_board_game_ctrl.sv
// tb_board_game_ctrl: directed vector bench for the board game turn sequencer.
module tb_board_game_ctrl;
   logic CLK = 1'b0, RESET = 1'b1;
   int   n_chk = 0, n_fail = 0;
   always #5 CLK = ~CLK;
   board_game_ctrl_if bus();
   board_game_ctrl dut (.CLK(CLK), .RESET(RESET), .bus(bus));

   typedef struct {
      logic [7:0]  key;
      logic [4:0]  cur;
      int          mk;
      int          il;
      logic [1:0]  st3;
      logic [17:0] board;
      logic        player;
      logic [1:0]  gs;
      logic [1:0]  winner;
      logic [7:0]  wl;
      logic [3:0]  cnt;
   } vec_t;
   vec_t vq[$];

   localparam logic [7:0] K_E = 8'd101, K_D = 8'd100, K_R = 8'd114, K_X = 8'd120;
   localparam logic [1:0] P = 2'd0, C = 2'd1, O = 2'd2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic press(input logic [7:0] k, output int mk_n, output int il_n,
                        output int mk_at, output logic [1:0] st3);
      @(negedge CLK);
      bus.ascii = k;
      bus.new_ascii = 1'b1;
      mk_n = 0; il_n = 0; mk_at = -1; st3 = 2'd3;
      for (int c = 1; c <= 8; c++) begin
         @(posedge CLK);
         #1;
         if (bus.move_key) begin
            mk_n++;
            if (mk_at < 0) mk_at = c;
         end
         if (bus.illegal) il_n++;
         if (c == 3) st3 = bus.game_state;
         if (c == 4) bus.new_ascii = 1'b0;
      end
   endtask

   task automatic add(input logic [7:0] k, input logic [4:0] cur, input int mk, input int il,
                      input logic [1:0] st3, input logic [17:0] b, input logic p, input logic [1:0] gs,
                      input logic [1:0] w, input logic [7:0] wl, input logic [3:0] cnt);
      vec_t v;
      v = '{k, cur, mk, il, st3, b, p, gs, w, wl, cnt};
      vq.push_back(v);
   endtask

   task automatic chk_outputs(input string tag, input logic [17:0] b, input logic p,
                              input logic [1:0] gs, input logic [1:0] w, input logic [7:0] wl,
                              input logic [3:0] cnt);
      chk({tag, " board"}, 32'(bus.board), 32'(b));
      chk({tag, " player"}, 32'(bus.player), 32'(p));
      chk({tag, " game_state"}, 32'(bus.game_state), 32'(gs));
      chk({tag, " winner"}, 32'(bus.winner), 32'(w));
      chk({tag, " win_line"}, 32'(bus.win_line), 32'(wl));
      chk({tag, " move_count"}, 32'(bus.move_count), 32'(cnt));
   endtask

   initial begin
      int mk_n, il_n, mk_at;
      logic [1:0] st3;
      bus.ascii = 8'd0;
      bus.new_ascii = 1'b0;
      bus.cursor = 5'd0;
      // move/illegal/restart basics
      add(K_D, 5, 1, 0, P, 18'h0, 0, P, 0, 8'h00, 0);
      add(K_E, 5, 0, 0, C, 18'h00100, 1, P, 0, 8'h00, 1);
      add(K_E, 5, 0, 1, P, 18'h00100, 1, P, 0, 8'h00, 1);
      add(K_X, 5, 0, 0, P, 18'h00100, 1, P, 0, 8'h00, 1);
      add(K_E, 0, 0, 1, P, 18'h00100, 1, P, 0, 8'h00, 1);
      add(K_E, 10, 0, 1, P, 18'h00100, 1, P, 0, 8'h00, 1);
      add(K_R, 5, 0, 0, P, 18'h0, 0, P, 0, 8'h00, 0);
      // X wins on the top row
      add(K_E, 1, 0, 0, C, 18'h00001, 1, P, 0, 8'h00, 1);
      add(K_E, 4, 0, 0, C, 18'h00081, 0, P, 0, 8'h00, 2);
      add(K_E, 2, 0, 0, C, 18'h00085, 1, P, 0, 8'h00, 3);
      add(K_E, 5, 0, 0, C, 18'h00285, 0, P, 0, 8'h00, 4);
      add(K_E, 3, 0, 0, C, 18'h00295, 0, O, 1, 8'h01, 5);
      add(K_D, 5, 0, 0, O, 18'h00295, 0, O, 1, 8'h01, 5);
      add(K_E, 6, 0, 0, O, 18'h00295, 0, O, 1, 8'h01, 5);
      add(K_R, 6, 0, 0, P, 18'h0, 0, P, 0, 8'h00, 0);
      // draw: 1X 2O 3X 5O 4X 6O 8X 7O 9X
      add(K_E, 1, 0, 0, C, 18'h00001, 1, P, 0, 8'h00, 1);
      add(K_E, 2, 0, 0, C, 18'h00009, 0, P, 0, 8'h00, 2);
      add(K_E, 3, 0, 0, C, 18'h00019, 1, P, 0, 8'h00, 3);
      add(K_E, 5, 0, 0, C, 18'h00219, 0, P, 0, 8'h00, 4);
      add(K_E, 4, 0, 0, C, 18'h00259, 1, P, 0, 8'h00, 5);
      add(K_E, 6, 0, 0, C, 18'h00A59, 0, P, 0, 8'h00, 6);
      add(K_E, 8, 0, 0, C, 18'h04A59, 1, P, 0, 8'h00, 7);
      add(K_E, 7, 0, 0, C, 18'h06A59, 0, P, 0, 8'h00, 8);
      add(K_E, 9, 0, 0, C, 18'h16A59, 0, O, 3, 8'h00, 9);
      add(K_D, 9, 0, 0, O, 18'h16A59, 0, O, 3, 8'h00, 9);
      add(K_R, 9, 0, 0, P, 18'h0, 0, P, 0, 8'h00, 0);
      // X wins both diagonals on the 9th mark
      add(K_E, 1, 0, 0, C, 18'h00001, 1, P, 0, 8'h00, 1);
      add(K_E, 2, 0, 0, C, 18'h00009, 0, P, 0, 8'h00, 2);
      add(K_E, 3, 0, 0, C, 18'h00019, 1, P, 0, 8'h00, 3);
      add(K_E, 4, 0, 0, C, 18'h00099, 0, P, 0, 8'h00, 4);
      add(K_E, 7, 0, 0, C, 18'h01099, 1, P, 0, 8'h00, 5);
      add(K_E, 6, 0, 0, C, 18'h01899, 0, P, 0, 8'h00, 6);
      add(K_E, 9, 0, 0, C, 18'h11899, 1, P, 0, 8'h00, 7);
      add(K_E, 8, 0, 0, C, 18'h19899, 0, P, 0, 8'h00, 8);
      add(K_E, 5, 0, 0, C, 18'h19999, 0, O, 1, 8'hC0, 9);
      add(K_R, 5, 0, 0, P, 18'h0, 0, P, 0, 8'h00, 0);

      repeat (2) @(posedge CLK);
      #1;
      chk_outputs("reset", 18'h0, 1'b0, P, 2'd0, 8'h00, 4'd0);
      chk("reset move_key", 32'(bus.move_key), 32'd0);
      chk("reset illegal", 32'(bus.illegal), 32'd0);
      @(negedge CLK);
      RESET = 1'b0;

      foreach (vq[n]) begin
         bus.cursor = vq[n].cur;
         press(vq[n].key, mk_n, il_n, mk_at, st3);
         chk($sformatf("v%0d move_key pulses", n), 32'(mk_n), 32'(vq[n].mk));
         chk($sformatf("v%0d illegal pulses", n), 32'(il_n), 32'(vq[n].il));
         chk($sformatf("v%0d state after key", n), 32'(st3), 32'(vq[n].st3));
         if (vq[n].mk == 1) chk($sformatf("v%0d move_key cycle", n), 32'(mk_at), 32'd3);
         chk_outputs($sformatf("v%0d", n), vq[n].board, vq[n].player, vq[n].gs,
                     vq[n].winner, vq[n].wl, vq[n].cnt);
      end

      // asynchronous reset while in CHECK
      bus.cursor = 5'd1;
      @(negedge CLK);
      bus.ascii = K_E;
      bus.new_ascii = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      chk("pre-reset state", 32'(bus.game_state), 32'(C));
      chk("pre-reset board", 32'(bus.board), 32'h1);
      #2 RESET = 1'b1;
      #1;
      chk_outputs("async reset", 18'h0, 1'b0, P, 2'd0, 8'h00, 4'd0);
      bus.new_ascii = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b0;

      // place with cursor out of range straight after reset
      bus.cursor = 5'd0;
      press(K_E, mk_n, il_n, mk_at, st3);
      chk("cur0 illegal pulses", 32'(il_n), 32'd1);
      chk("cur0 move_key pulses", 32'(mk_n), 32'd0);
      chk_outputs("cur0", 18'h0, 1'b0, P, 2'd0, 8'h00, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
